// File: rtl/bcd_display_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_display_ctrl
//
// Converts an 8-bit unsigned binary value into three BCD digits and
// time-multiplexes them onto one shared active-low 7-segment bus.
//
// Conversion uses the iterative shift-and-add-3 (double dabble) method. It
// processes one input bit per clock: accept in IDLE, eight CONV steps, then
// one DONE cycle that publishes the result. The published result (bcd_out)
// is what drives the display, so partial results are never shown.
//
// The scan logic runs free and independently of the conversion FSM. Each
// digit stays enabled for SCAN_DIV cycles. an and seg are both registered
// from the same next-digit index, so they always change on the same edge.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   defined   - a hundreds digit of 0 is blanked, and a tens digit of 0 is
//               blanked when hundreds is also 0. The ones digit is always
//               lit, and the digit enables keep cycling.
//   undefined - all three digits are always shown, leading zeros included.
//
// Parameters:
//   SCAN_DIV   clock cycles per digit, 1 .. 2^20-1
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   source presents in_data
//   in_data    [7:0] unsigned binary value to display
//   in_ready   block can accept (IDLE only)
//   busy       conversion in progress (CONV or DONE)
//   bcd_out    [11:0] last completed result {hundreds, tens, ones}
//   bcd_valid  one-cycle pulse when bcd_out updates
//   seg        [6:0] active-low segments, seg[6]=a ... seg[0]=g
//   an         [2:0] active-low digit enables, an[0]=ones ... an[2]=hundreds
// -----------------------------------------------------------------------------
module bcd_display_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] work_q, work_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] bcd_out_q, bcd_out_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic [19:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  digit_idx_q, digit_idx_d;
    logic [2:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic [11:0] work_adj;
    logic [3:0]  digit_nib;
    logic        digit_blank;

    // Double-dabble correction: a nibble >= 5 would become >= 10 after the
    // shift, so pre-add 3 to carry it into the next decimal digit.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked processes use non-blocking (<=) so that every flop
    // samples the pre-edge values of the others, whatever the process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default assignment first, so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)            state_d = ST_CONV;
            ST_CONV: if (bit_cnt_q == 4'd7)   state_d = ST_DONE;
            ST_DONE:                          state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = (state_q == ST_CONV) || (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    always_comb begin
        work_adj    = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
        shift_d     = shift_q;
        work_d      = work_q;
        bit_cnt_d   = bit_cnt_q;
        bcd_out_d   = bcd_out_q;
        bcd_valid_d = (state_q == ST_DONE);

        if (state_q == ST_IDLE && in_valid) begin
            shift_d   = in_data;
            work_d    = '0;
            bit_cnt_d = '0;
        end else if (state_q == ST_CONV) begin
            // The shift register MSB moves into work[0].
            {work_d, shift_d} = {work_adj, shift_q} << 1;
            bit_cnt_d         = bit_cnt_q + 4'd1;
        end

        if (state_q == ST_DONE) begin
            bcd_out_d = work_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            work_q      <= '0;
            bit_cnt_q   <= '0;
            bcd_out_q   <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            work_q      <= work_d;
            bit_cnt_q   <= bit_cnt_d;
            bcd_out_q   <= bcd_out_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    // an and seg are both registered from the next-cycle index and the
    // next-cycle bcd_out. This keeps them aligned, and a new result appears
    // on the same edge that bcd_out changes.
    always_comb begin
        scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? 20'd0 : scan_cnt_q + 20'd1;
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
        end

        case (digit_idx_d)
            2'd0: begin
                an_d      = 3'b110;
                digit_nib = bcd_out_d[3:0];
            end
            2'd1: begin
                an_d      = 3'b101;
                digit_nib = bcd_out_d[7:4];
            end
            default: begin
                an_d      = 3'b011;
                digit_nib = bcd_out_d[11:8];
            end
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        digit_blank = ((digit_idx_d == 2'd2) && (bcd_out_d[11:8] == 4'd0)) ||
                      ((digit_idx_d == 2'd1) && (bcd_out_d[11:4] == 8'd0));
`else
        digit_blank = 1'b0;
`endif

        seg_d = digit_blank ? SEG_BLANK : seg_decode(digit_nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            an_q        <= 3'b110;
            seg_q       <= 7'b0000001;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bcd_out   = bcd_out_q;
    assign bcd_valid = bcd_valid_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_ctrl
//
// Self-checking bench for bcd_display_ctrl, built with SCAN_DIV = 4.
//
// The reference model tracks only what the outside world can observe:
//   - an accept starts a 9-cycle busy window;
//   - the decimal value of the accepted input is published at the end of
//     that window;
//   - the scan position is the number of cycles since reset divided by
//     SCAN_DIV, modulo 3.
// Every negedge, one compare process checks all outputs against the model.
// Directed sequences add literal expectations on top of that.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_display_ctrl;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'd0;
    logic        in_ready;
    logic        busy;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  an;

    bcd_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [6:0] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx);
        int d [3];
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = v / 100;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2 && d[2] == 0) return 7'b1111111;
        if (idx == 1 && d[2] == 0 && d[1] == 0) return 7'b1111111;
`endif
        return seg_tbl[d[idx]];
    endfunction

    int m_cycle = 0;   // clock edges since reset released
    int m_busy  = 0;   // cycles left before the pending result is published
    int m_val   = 0;   // last published value (decimal)
    int m_pend  = 0;   // value being converted
    bit m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cycle = 0;
            m_busy  = 0;
            m_val   = 0;
            m_valid = 1'b0;
        end else begin
            m_cycle++;
            m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_val   = m_pend;
                    m_valid = 1'b1;
                end
            end else if (in_valid) begin
                m_pend = int'(in_data);
                m_busy = 9;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    bit         chk_en = 1'b0;
    int         c_idx;
    logic [2:0] c_an;

    always @(negedge clk) begin
        if (chk_en) begin
            c_idx = int'((m_cycle / SCAN_DIV) % 3);
            c_an  = ~(3'b001 << c_idx);
            check("cmp_in_ready",  32'(in_ready),  32'(m_busy == 0));
            check("cmp_busy",      32'(busy),      32'(m_busy != 0));
            check("cmp_bcd_out",   32'(bcd_out),   32'(to_bcd(m_val)));
            check("cmp_bcd_valid", 32'(bcd_valid), 32'(m_valid));
            check("cmp_an",        32'(an),        32'(c_an));
            check("cmp_seg",       32'(seg),       32'(exp_seg(m_val, c_idx)));
        end
    end

    // Result monitor and cycle counter
    int          tb_cyc    = 0;
    int          valid_cnt = 0;
    logic [11:0] results [$];

    always @(posedge clk) tb_cyc++;

    always @(negedge clk) begin
        if (rst_n && bcd_valid === 1'b1) begin
            valid_cnt++;
            results.push_back(bcd_out);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Present v, wait (bounded) for in_ready, and return just after the
    // accepting edge with in_valid dropped.
    task automatic send(input logic [7:0] v);
        int i = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && i < 30) begin
            i++;
            @(negedge clk);
        end
        check("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, output logic [11:0] r);
        int i = 0;
        @(negedge clk);
        while (bcd_valid !== 1'b1 && i < 40) begin
            i++;
            @(negedge clk);
        end
        check({name, "_valid"}, 32'(bcd_valid), 32'd1);
        r = bcd_out;
    endtask

    task automatic check_digit(input logic [2:0] a, input logic [6:0] s, input string name);
        int i = 0;
        @(negedge clk);
        while (an !== a && i < 3 * SCAN_DIV + 2) begin
            i++;
            @(negedge clk);
        end
        check({name, "_an"}, 32'(an), 32'(a));
        check(name, 32'(seg), 32'(s));
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [11:0] r;
        int          n;
        int          t_prev;
        int          base;
        int          j;

        // Reset
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_bcd_out",  32'(bcd_out),  32'h000);
        check("rst_an",       32'(an),       32'(3'b110));
        check("rst_seg",      32'(seg),      32'(7'b0000001));
        #1 rst_n = 1'b1;

        // Scan sequence after reset
        repeat (SCAN_DIV) @(posedge clk);
        @(negedge clk);
        check("scan_an1", 32'(an), 32'(3'b101));
        repeat (SCAN_DIV) @(posedge clk);
        @(negedge clk);
        check("scan_an2", 32'(an), 32'(3'b011));
        repeat (SCAN_DIV) @(posedge clk);
        @(negedge clk);
        check("scan_an0", 32'(an), 32'(3'b110));

        // Single conversion: 255
        send(8'd255);
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("c255_busy_cycles", 32'(n), 32'd9);
        check("c255_valid",       32'(bcd_valid), 32'd1);
        check("c255_bcd",         32'(bcd_out), 32'h255);
        check_digit(3'b110, 7'b0100100, "c255_ones");
        check_digit(3'b101, 7'b0100100, "c255_tens");
        check_digit(3'b011, 7'b0010010, "c255_hund");

        // Exhaustive back-to-back 0..255
        results.delete();
        base   = valid_cnt;
        t_prev = 0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int v = 0; v < 256; v++) begin
            in_data = 8'(v);
            j = 0;
            while (!in_ready && j < 30) begin
                j++;
                @(negedge clk);
            end
            check("exh_ready", 32'(in_ready), 32'd1);
            if (v > 0) check("exh_interval", 32'(tb_cyc - t_prev), 32'd10);
            t_prev = tb_cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_result("exh_last", r);
        @(negedge clk);
        check("exh_pulses",  32'(valid_cnt - base), 32'd256);
        check("exh_results", 32'(results.size()), 32'd256);
        for (int v = 0; v < 256 && v < results.size(); v++) begin
            check("exh_value", 32'(results[v]), 32'(to_bcd(v)));
        end

        // Handshake: 7 is held during the conversion of 42
        send(8'd42);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd7;
        check("hs_not_ready", 32'(in_ready), 32'd0);
        wait_result("hs42", r);
        check("hs_first", 32'(r), 32'h042);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("hs_busy", 32'(busy),    32'd1);
            check("hs_hold", 32'(bcd_out), 32'h042);
        end
        wait_result("hs7", r);
        check("hs_second", 32'(r), 32'h007);

        // Reset during CONV step 4
        send(8'd200);
        repeat (3) @(posedge clk);
        @(negedge clk);
        base = valid_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_bcd_out",   32'(bcd_out),   32'h000);
        check("mid_rst_bcd_valid", 32'(bcd_valid), 32'd0);
        check("mid_rst_an",        32'(an),        32'(3'b110));
        check("mid_rst_seg",       32'(seg),       32'(7'b0000001));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_rst_no_pulse", 32'(valid_cnt), 32'(base));
        send(8'd9);
        wait_result("after_rst", r);
        check("after_rst_bcd", 32'(r), 32'h009);

`ifdef LEADING_ZERO_BLANK_EN
        send(8'd5);
        wait_result("lz5", r);
        check_digit(3'b011, 7'b1111111, "lz5_hund");
        check_digit(3'b101, 7'b1111111, "lz5_tens");
        check_digit(3'b110, 7'b0100100, "lz5_ones");
        send(8'd105);
        wait_result("lz105", r);
        check_digit(3'b101, 7'b0000001, "lz105_tens");
        send(8'd0);
        wait_result("lz0", r);
        check_digit(3'b011, 7'b1111111, "lz0_hund");
        check_digit(3'b101, 7'b1111111, "lz0_tens");
        check_digit(3'b110, 7'b0000001, "lz0_ones");
`else
        send(8'd5);
        wait_result("nz5", r);
        check_digit(3'b011, 7'b0000001, "nz5_hund");
        check_digit(3'b101, 7'b0000001, "nz5_tens");
        check_digit(3'b110, 7'b0100100, "nz5_ones");
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
